action_queue: RTL
=================

Name: action_queue

Overview:
- Receiving end of the one-cycle button pulses produced by the per-button debounce/edge blocks.
- Latches the left, right, rotate and drop pulses.
- Arbitrates simultaneous requests by fixed priority.
- Buffers actions in a small FIFO.
- Presents them one at a time to the game-logic FSM over a valid/ready handshake, so no button press is lost while the FSM is busy, e.g. while clearing lines.

Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- LVL_W, $clog2(DEPTH)+1: width of the level output.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- flush, input, 1: synchronous clear of the queue and pending flags (game over / new game).
- btn_left, input, 1: one-cycle press pulse.
- btn_right, input, 1: one-cycle press pulse.
- btn_rotate, input, 1: one-cycle press pulse.
- btn_drop, input, 1: one-cycle press pulse.
- act_valid, output, 1: head of the FIFO is valid.
- act_code, output, 2: head action; 00 left, 01 right, 10 rotate, 11 drop.
- act_ready, input, 1: consumer accepts the head this cycle.
- level, output, LVL_W: number of entries in the FIFO (0..DEPTH).
- dropped, output, 1: one-cycle pulse when a press is coalesced into an already-pending flag.

Behaviour:
- Reset (rst_n low, asynchronous): act_valid=0, act_code=00, level=0, dropped=0, all pending flags=0, read and write pointers=0.
- Pending stage: four sticky flags, one per action.
  - A btn_x pulse sets pend_x at the next edge.
  - If pend_x is already 1 and not cleared in the same cycle, the press is coalesced and dropped pulses the next cycle.
  - If pend_x is cleared (pushed) in the same cycle a new btn_x arrives, the flag stays set (new press retained) and dropped=0.
- Arbiter:
  - Each cycle, if any pend_x=1 and the FIFO can accept, push exactly one code.
  - Priority order: drop > rotate > left > right.
  - Clear that flag at the same edge.
- FIFO can accept when level<DEPTH, or when level==DEPTH and act_valid & act_ready in the same cycle (push and pop coincide; level unchanged).
- FIFO full with no pop: pending flags hold; nothing is lost except coalesced repeats.
- Output handshake:
  - act_valid = (level != 0).
  - act_code = head entry, registered/stable while act_valid & !act_ready.
  - A pop occurs on an edge with act_valid & act_ready.
  - act_ready while act_valid=0 is ignored.
- Latency: pulse at edge E into empty idle queue → pend at E+1 → act_valid=1 with code after edge E+2, i.e. 2 cycles.
- Throughput: one push and one pop per cycle max.
- level:
  - +1 on push only, −1 on pop only, unchanged on both or neither.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- flush (synchronous, dominates everything):
  - At the edge: pointers=0, level=0, pending=0, dropped=0.
  - Pulses and act_ready in the flush cycle are ignored.
  - act_valid=0 from the next cycle.
- Reset mid-operation: immediate return to reset values; FIFO contents need not be cleared, pointers only.

Decomposition:
- Shared package (tetris_pkg): action code constants ACT_LEFT=2'd0, ACT_RIGHT=2'd1, ACT_ROT=2'd2, ACT_DROP=2'd3. The game FSM uses the same constants.
- One natural sub-module: sync_fifo. Parameterised DEPTH/WIDTH, push/pop/full/empty/level, flush input, async active-low reset. The arbiter and pending flags stay in the top module.

Test Plan:
- Reset then single btn_rotate pulse with act_ready=1 → act_valid high exactly 2 cycles after the pulse with act_code=10 for one cycle, then level=0.
- btn_left, btn_right, btn_drop pulsed in the same cycle with act_ready=0 → after 4 cycles level=3; popping yields 11, 00, 01 in that order.
- act_ready=0, DEPTH=4: pulse btn_left 6 times, spaced 3 cycles apart → level saturates at 4, pend_left held, no dropped on the 5th press, dropped=1 on the 6th; then 5 pops of code 00, then empty.
- FIFO full with one pend_right, act_ready=1 for one cycle → same edge pops and pushes, level stays 4, new tail code 01.
- Queue holding 3 entries; assert flush together with btn_drop and act_ready → next cycle level=0, act_valid=0, no 11 ever appears.
- Deassert rst_n asynchronously mid-stream with level=2 → outputs go to reset values before the next clk edge; after release, the first press behaves as in scenario 1.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared action-code definitions used by the input queue and the game FSM.
package tetris_pkg;

  typedef logic [1:0] act_t;

  localparam act_t ACT_LEFT  = 2'd0;
  localparam act_t ACT_RIGHT = 2'd1;
  localparam act_t ACT_ROT   = 2'd2;
  localparam act_t ACT_DROP  = 2'd3;

  localparam int NUM_ACT = 4;

  function automatic logic [NUM_ACT-1:0] act_onehot(input act_t code);
    act_onehot = NUM_ACT'(1) << code;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, synchronous flush and
// combinational head output (zero when empty).
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO may still take a push when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  // Storage is data only; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/action_queue.sv
// Latches button pulses into sticky pending flags, arbitrates them by fixed
// priority (drop > rotate > left > right) and queues them for the game FSM.
module action_queue
  import tetris_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_rotate,
  input  logic             btn_drop,
  output logic             act_valid,
  output logic [1:0]       act_code,
  input  logic             act_ready,
  output logic [LVL_W-1:0] level,
  output logic             dropped
);

  logic [NUM_ACT-1:0] pend;
  logic [NUM_ACT-1:0] btn;
  logic [NUM_ACT-1:0] clr;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               can_accept;
  logic               push;
  act_t               grant_code;

  assign btn = {btn_drop, btn_rotate, btn_right, btn_left};

  assign act_valid  = ~fifo_empty;
  assign pop        = act_valid & act_ready;
  assign can_accept = ~fifo_full | pop;
  assign push       = (|pend) & can_accept & ~flush;

  always_comb begin
    grant_code = ACT_RIGHT;
    if (pend[ACT_DROP])      grant_code = ACT_DROP;
    else if (pend[ACT_ROT])  grant_code = ACT_ROT;
    else if (pend[ACT_LEFT]) grant_code = ACT_LEFT;
  end

  assign clr = push ? act_onehot(grant_code) : '0;

  // Pending stage: a press arriving while its flag is being pushed is kept;
  // a press onto a flag that stays set is coalesced and reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      dropped <= 1'b0;
    end else if (flush) begin
      pend    <= '0;
      dropped <= 1'b0;
    end else begin
      pend    <= (pend & ~clr) | btn;
      dropped <= |(btn & pend & ~clr);
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (grant_code),
    .dout  (act_code),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

endmodule
